// File: rtl/issue_buf.sv
// In-order issue buffer between the decoder and one execution unit.
// Optional build macro: ISSUE_BYPASS_EN adds a same-cycle fall-through path
// from decoded_* to issued_* when the buffer is empty.

package issue_buf_pkg;

    // Decoded-instruction payload shared by decoder, issue buffer and execution units.
    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } decoded_instr_t;

endpackage

module issue_buf
    import issue_buf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     decoded_valid_i,
    output logic                     decoded_ready_o,
    input  decoded_instr_t           decoded_data_i,
    output logic                     issued_valid_o,
    input  logic                     issued_ready_i,
    output decoded_instr_t           issued_data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    decoded_instr_t   mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    // Low while in reset, high from the first edge after; keeps ready low during reset.
    logic             live_q;

    logic not_full;
    logic not_empty;
    logic bypass_hit;
    logic enq;
    logic deq;
    logic wr_en;
    logic rd_en;

    // Handshake decode, head selection and optional fall-through.
    always_comb begin
        not_full   = (count_q != CNT_W'(DEPTH));
        not_empty  = (count_q != '0);
        bypass_hit = 1'b0;
`ifdef ISSUE_BYPASS_EN
        bypass_hit = live_q && !not_empty && !flush_i && decoded_valid_i;
`endif
        decoded_ready_o = live_q && not_full && !flush_i;
        issued_valid_o  = (live_q && not_empty && !flush_i) || bypass_hit;
        issued_data_o   = bypass_hit ? decoded_data_i : mem_q[rd_ptr_q];
        enq   = decoded_valid_i && decoded_ready_o;
        deq   = issued_valid_o && issued_ready_i;
        // A bypassed entry consumed in the same cycle never occupies a slot.
        wr_en = enq && !(bypass_hit && issued_ready_i);
        rd_en = deq && not_empty;
        count_o = count_q;
    end

    // Next-state for pointers and occupancy; flush wins over any handshake.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            live_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            live_q   <= 1'b1;
        end
    end

    // Payload storage, intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= decoded_data_i;
    end

endmodule

// File: tb/tb_issue_buf.sv
// Directed, table-driven bench for issue_buf (DEPTH=4).
// Default build checks the registered path; with ISSUE_BYPASS_EN the
// fall-through sequence replaces the registered-latency table.
module tb_issue_buf;
    import issue_buf_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic           clk;
    logic           rst;
    logic           flush;
    logic           dv;
    logic           dr;
    decoded_instr_t dd;
    logic           iv;
    logic           ir;
    decoded_instr_t id;
    logic [2:0]     cnt;

    int tests_run;
    int tests_failed;

    issue_buf #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (flush),
        .decoded_valid_i (dv),
        .decoded_ready_o (dr),
        .decoded_data_i  (dd),
        .issued_valid_o  (iv),
        .issued_ready_i  (ir),
        .issued_data_o   (id),
        .count_o         (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       fl;
        logic       v;
        logic [7:0] d;
        logic       r;
        logic       e_dr;
        logic       e_iv;
        logic [7:0] e_d;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t vq[$];

    function automatic decoded_instr_t mk(input logic [7:0] t);
        decoded_instr_t p;
        p.pc     = {24'h0, t};
        p.opcode = t[6:0];
        p.rd     = t[4:0];
        p.rs1    = ~t[4:0];
        p.rs2    = t[7:3];
        p.imm    = {t, ~t, t, ~t};
        return p;
    endfunction

    task automatic chk(input string name, input int idx, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
        end
    endtask

    task automatic add(input logic fl, input logic v, input logic [7:0] d, input logic r,
                       input logic e_dr, input logic e_iv, input logic [7:0] e_d, input logic [2:0] e_cnt);
        vec_t x;
        x.fl = fl; x.v = v; x.d = d; x.r = r;
        x.e_dr = e_dr; x.e_iv = e_iv; x.e_d = e_d; x.e_cnt = e_cnt;
        vq.push_back(x);
    endtask

    // Drive at negedge, check #1 later (before the next rising edge).
    task automatic step(input string name, input int idx, input vec_t x);
        @(negedge clk);
        flush = x.fl; dv = x.v; dd = mk(x.d); ir = x.r;
        #1;
        chk({name, ".ready"}, idx, 128'(dr), 128'(x.e_dr));
        chk({name, ".valid"}, idx, 128'(iv), 128'(x.e_iv));
        chk({name, ".count"}, idx, 128'(cnt), 128'(x.e_cnt));
        if (x.e_iv) chk({name, ".data"}, idx, 128'(id), 128'(mk(x.e_d)));
    endtask

    initial begin
        vec_t h;
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1; flush = 1'b0; dv = 1'b0; ir = 1'b0; dd = mk(8'hEE);

        // Fill A..E with ready low: E refused, head A held stable.
        add(0,1,8'hA1,0, 1,0,8'h00,0);
        add(0,1,8'hB2,0, 1,1,8'hA1,1);
        add(0,1,8'hC3,0, 1,1,8'hA1,2);
        add(0,1,8'hD4,0, 1,1,8'hA1,3);
        add(0,1,8'hE5,0, 0,1,8'hA1,4);
        // Drain in order; data ignored while valid low.
        add(0,0,8'hEE,1, 0,1,8'hA1,4);
        add(0,0,8'hEE,1, 1,1,8'hB2,3);
        add(0,0,8'hEE,1, 1,1,8'hC3,2);
        add(0,0,8'hEE,1, 1,1,8'hD4,1);
        add(0,0,8'hEE,1, 1,0,8'h00,0);
        // Steady state, 10 transfers with valid and ready held high.
        add(0,1,8'h10,1, 1,0,8'h00,0);
        for (int k = 1; k < 10; k++)
            add(0,1,8'(8'h10 + k),1, 1,1,8'(8'h10 + k - 1),1);
        add(0,0,8'hEE,1, 1,1,8'h19,1);
        add(0,0,8'hEE,0, 1,0,8'h00,0);
        // Flush at count 3 with a valid input that must be dropped.
        add(0,1,8'h21,0, 1,0,8'h00,0);
        add(0,1,8'h22,0, 1,1,8'h21,1);
        add(0,1,8'h23,0, 1,1,8'h21,2);
        add(1,1,8'h24,1, 0,0,8'h00,3);
        add(0,0,8'hEE,0, 1,0,8'h00,0);
        add(0,1,8'h25,0, 1,0,8'h00,0);
        add(0,0,8'hEE,1, 1,1,8'h25,1);
        add(0,0,8'hEE,0, 1,0,8'h00,0);
        // Full with simultaneous valid/ready: dequeue only, no pass-through.
        add(0,1,8'h31,0, 1,0,8'h00,0);
        add(0,1,8'h32,0, 1,1,8'h31,1);
        add(0,1,8'h33,0, 1,1,8'h31,2);
        add(0,1,8'h34,0, 1,1,8'h31,3);
        add(0,1,8'h35,1, 0,1,8'h31,4);
        add(0,1,8'h35,1, 1,1,8'h32,3);
        add(0,0,8'hEE,1, 1,1,8'h33,3);
        add(0,0,8'hEE,1, 1,1,8'h34,2);
        add(0,0,8'hEE,1, 1,1,8'h35,1);
        add(0,0,8'hEE,0, 1,0,8'h00,0);

        // Reset state while rst is high.
        repeat (2) @(negedge clk);
        dv = 1'b1;
        #1;
        chk("rst.ready", 0, 128'(dr), 128'(0));
        chk("rst.valid", 0, 128'(iv), 128'(0));
        chk("rst.count", 0, 128'(cnt), 128'(0));
        @(negedge clk);
        dv = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst.ready", 0, 128'(dr), 128'(1));
        chk("post_rst.count", 0, 128'(cnt), 128'(0));

`ifndef ISSUE_BYPASS_EN
        foreach (vq[i]) step("vec", i, vq[i]);
`else
        // Fall-through consumed in the same cycle.
        h.fl = 0; h.v = 1; h.d = 8'h51; h.r = 1; h.e_dr = 1; h.e_iv = 1; h.e_d = 8'h51; h.e_cnt = 0;
        step("byp", 0, h);
        h.v = 0; h.d = 8'hEE; h.e_iv = 0;
        step("byp", 1, h);
        // Fall-through not accepted downstream: stored normally.
        h.v = 1; h.d = 8'h52; h.r = 0; h.e_iv = 1; h.e_d = 8'h52;
        step("byp", 2, h);
        h.v = 0; h.d = 8'hEE; h.r = 1; h.e_cnt = 1;
        step("byp", 3, h);
        h.r = 0; h.e_iv = 0; h.e_cnt = 0;
        step("byp", 4, h);
`endif

        // Asynchronous reset mid-cycle with two entries buffered.
        h.fl = 0; h.v = 1; h.d = 8'h61; h.r = 0; h.e_dr = 1; h.e_iv = 0; h.e_d = 8'h00; h.e_cnt = 0;
`ifdef ISSUE_BYPASS_EN
        h.e_iv = 1; h.e_d = 8'h61;
`endif
        step("ar", 0, h);
        h.d = 8'h62; h.e_iv = 1; h.e_d = 8'h61; h.e_cnt = 1;
        step("ar", 1, h);
        h.v = 0; h.d = 8'hEE; h.e_cnt = 2;
        step("ar", 2, h);
        #1 rst = 1'b1;
        #1;
        chk("ar.valid", 3, 128'(iv), 128'(0));
        chk("ar.count", 3, 128'(cnt), 128'(0));
        chk("ar.ready", 3, 128'(dr), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        h.e_dr = 1; h.e_iv = 0; h.e_cnt = 0;
        step("ar", 4, h);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/issue_buf.md
ISSUE_BUF -- requirements
Module: issue_buf

Interface
REQ-001 Parameter: DEPTH, default 4, number of buffered decoded-instruction entries; power of two, minimum 2.
REQ-002 Port: clk  input  1  single clock, all state on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: flush  input  1  discard all buffered entries (branch redirect).
REQ-005 Port: decoded  decoupled.in  valid/ready/data  decoded-instruction stream from the decoder; data is the shared decoded-instruction struct.
REQ-006 Port: issued  decoupled.out  valid/ready/data  decoded-instruction stream to one execution unit; same payload type.
REQ-007 Port: count  output  $clog2(DEPTH)+1  current number of valid entries.

Function
REQ-008 Block SHALL be an in-order FIFO between the decoder and an execution unit: entries leave in arrival order, payload unmodified.
REQ-009 Enqueue SHALL occur on a rising edge when decoded.valid && decoded.ready.
REQ-010 Dequeue SHALL occur on a rising edge when issued.valid && issued.ready.
REQ-011 decoded.ready SHALL be (count != DEPTH) && !flush; there is no enqueue pass-through when full, even with a simultaneous dequeue.
REQ-012 issued.valid SHALL be (count != 0) && !flush, except as extended by REQ-023.
REQ-013 issued.data SHALL be the head entry whenever count != 0.
REQ-014 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH with no skipped slot.
REQ-015 count SHALL be +1 on enqueue only, -1 on dequeue only, and unchanged on simultaneous enqueue and dequeue.
REQ-016 Minimum latency, decoded handshake to issued.valid, SHALL be 1 cycle with ISSUE_BYPASS_EN undefined.
REQ-017 Flush:
- a cycle with flush high SHALL perform no enqueue or dequeue;
- on the next edge, both pointers and count SHALL be 0.
REQ-018 Flush SHALL take priority over every simultaneous handshake.
REQ-019 issued.data and issued.valid SHALL be stable while issued.valid && !issued.ready, absent flush.
REQ-020 Block SHALL ignore decoded.data when decoded.valid is low.

Reset
REQ-021 While rst is high, asynchronously:
- pointers = 0, count = 0;
- issued.valid = 0;
- decoded.ready = 0.
Payload storage is not reset.
REQ-022 On the first edge after rst deasserts:
- decoded.ready SHALL be 1;
- reset mid-transfer SHALL lose all entries with no partial state.

Configuration
REQ-023 Macro ISSUE_BYPASS_EN, when defined, SHALL add a fall-through path.
- Condition: count == 0, !flush, decoded.valid = 1.
- Then issued.valid = 1 and issued.data = decoded.data in the same cycle.
- If issued.ready is also 1, the entry is consumed without being stored and count stays 0.
- If issued.ready is 0, the entry is stored normally.
REQ-024 With ISSUE_BYPASS_EN undefined, no combinational path SHALL exist from decoded to issued; latency is per REQ-016.

Verification
REQ-025 Fill: DEPTH=4, issued.ready=0, 5 consecutive valid inputs A..E -> A..D accepted; decoded.ready=0 on the 5th cycle; count=4.
REQ-026 Drain order: from full (A..D), issued.ready=1 -> issued.data A, B, C, D on 4 consecutive cycles; count reaches 0; then issued.valid=0.
REQ-027 Wrap and steady-state: 10 transfers with valid and ready both held high -> output sequence equals input sequence; count constant at 1 (bypass off) or 0 (bypass on); pointers wrap correctly.
REQ-028 Flush: count=3 and flush pulsed 1 cycle with decoded.valid=1 -> that input is not accepted; next cycle count=0 and issued.valid=0.
REQ-029 Async reset: rst asserted mid-cycle at count=2 -> issued.valid=0 and count=0 before the next edge.
REQ-030 Bypass (macro defined): empty buffer, decoded.valid=1, issued.ready=1 -> issued.valid=1 in the same cycle with matching data; count stays 0.
